pipelined_backend: RTL

//  Parametrised 3-stage EX/MEM/WB back-end; successor to the single-cycle datapath (alu, memory_stage, write_back_stage).

---
 rtl/pipelined_backend.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pipelined_backend.sv
// Three-stage EX/MEM/WB back-end: operand forwarding, load-use stall, flush,
// wrapping synchronous data memory and a retire counter.
module pipelined_backend #(
  parameter int DATA_W    = 16,
  parameter int REG_AW    = 3,
  parameter int MEM_DEPTH = 256,
  parameter int CNT_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               alu_op,
  input  logic                     reg_write,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [1:0]               wb_sel,
  input  logic [REG_AW-1:0]        rs1,
  input  logic [REG_AW-1:0]        rs2,
  input  logic [REG_AW-1:0]        rd,
  input  logic signed [DATA_W-1:0] op1,
  input  logic signed [DATA_W-1:0] op2,
  input  logic signed [DATA_W-1:0] imm,
  input  logic                     flush,
  output logic                     wb_en,
  output logic [REG_AW-1:0]        wb_addr,
  output logic signed [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]         retired
);

  localparam int         MEM_AW  = $clog2(MEM_DEPTH);
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b01;
  localparam logic [1:0] WB_MEM  = 2'b10;

  function automatic logic signed [DATA_W-1:0] alu_f(
    input logic [1:0]               op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    case (op)
      OP_ADD:  alu_f = a + b;
      OP_SUB:  alu_f = a - b;
      OP_AND:  alu_f = a & b;
      default: alu_f = a | b;
    endcase
  endfunction

  // MEM-stage result has priority over WB; otherwise the captured operand stands.
  function automatic logic signed [DATA_W-1:0] fwd_f(
    input logic [REG_AW-1:0]        rs,
    input logic signed [DATA_W-1:0] cur,
    input logic                     mem_ok,
    input logic [REG_AW-1:0]        mem_rd,
    input logic signed [DATA_W-1:0] mem_val,
    input logic                     wb_ok,
    input logic [REG_AW-1:0]        wb_rd,
    input logic signed [DATA_W-1:0] wb_val
  );
    if (mem_ok && (mem_rd == rs))
      fwd_f = mem_val;
    else if (wb_ok && (wb_rd == rs))
      fwd_f = wb_val;
    else
      fwd_f = cur;
  endfunction

  logic                     vld_p0;
  logic [1:0]               alu_op_p0;
  logic [1:0]               wb_sel_p0;
  logic                     reg_write_p0;
  logic                     load_p0;
  logic                     mem_write_p0;
  logic [REG_AW-1:0]        rs1_p0;
  logic [REG_AW-1:0]        rs2_p0;
  logic [REG_AW-1:0]        rd_p0;
  logic signed [DATA_W-1:0] op1_p0;
  logic signed [DATA_W-1:0] op2_p0;
  logic signed [DATA_W-1:0] imm_p0;

  logic                     vld_p1;
  logic                     reg_write_p1;
  logic                     load_p1;
  logic                     mem_write_p1;
  logic                     mem_sel_p1;
  logic [REG_AW-1:0]        rd_p1;
  logic [MEM_AW-1:0]        addr_p1;
  logic signed [DATA_W-1:0] res_p1;
  logic signed [DATA_W-1:0] st_p1;

  logic                     vld_p2;
  logic                     reg_write_p2;

  logic                     load_use;
  logic                     accept;
  logic signed [DATA_W-1:0] op1_cap;
  logic signed [DATA_W-1:0] op2_cap;
  logic                     mem_fwd_ok;
  logic signed [DATA_W-1:0] op1_ex;
  logic signed [DATA_W-1:0] op2_ex;
  logic signed [DATA_W-1:0] alu_ex;
  logic signed [DATA_W-1:0] res_ex;
  logic signed [DATA_W-1:0] mem_rd;

  logic signed [DATA_W-1:0] mem [MEM_DEPTH];

  assign wb_en = vld_p2 & reg_write_p2;

  // Capture (input -> p0): a result sitting in WB is newer than the register file read.
  assign load_use = vld_p0 && load_p0 && reg_write_p0 && in_valid &&
                    ((rd_p0 == rs1) || (rd_p0 == rs2));
  assign in_ready = rst && !flush && !load_use;
  assign accept   = in_valid && in_ready;
  assign op1_cap  = (wb_en && (wb_addr == rs1)) ? wb_data : op1;
  assign op2_cap  = (wb_en && (wb_addr == rs2)) ? wb_data : op2;

  // EX (p0 -> p1): loads cannot bypass from MEM, their data is not read yet.
  assign mem_fwd_ok = vld_p1 && reg_write_p1 && !load_p1;
  assign op1_ex = fwd_f(rs1_p0, op1_p0, mem_fwd_ok, rd_p1, res_p1, wb_en, wb_addr, wb_data);
  assign op2_ex = fwd_f(rs2_p0, op2_p0, mem_fwd_ok, rd_p1, res_p1, wb_en, wb_addr, wb_data);
  assign alu_ex = alu_f(alu_op_p0, op1_ex, op2_ex);
  assign res_ex = (wb_sel_p0 == WB_IMM) ? imm_p0 : alu_ex;

  // MEM (p1 -> p2): the read sees the old word even when the same slot stores.
  assign mem_rd = mem[addr_p1];

  always_ff @(posedge clk) begin
    if (rst && vld_p1 && mem_write_p1)
      mem[addr_p1] <= st_p1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      alu_op_p0    <= alu_op;
      wb_sel_p0    <= wb_sel;
      reg_write_p0 <= reg_write;
      load_p0      <= mem_read | (wb_sel == WB_MEM);
      mem_write_p0 <= mem_write;
      rs1_p0       <= rs1;
      rs2_p0       <= rs2;
      rd_p0        <= rd;
      op1_p0       <= op1_cap;
      op2_p0       <= op2_cap;
      imm_p0       <= imm;
    end
    reg_write_p1 <= reg_write_p0;
    load_p1      <= load_p0;
    mem_write_p1 <= mem_write_p0;
    mem_sel_p1   <= (wb_sel_p0 == WB_MEM);
    rd_p1        <= rd_p0;
    addr_p1      <= alu_ex[MEM_AW-1:0];
    res_p1       <= res_ex;
    st_p1        <= op2_ex;
    reg_write_p2 <= reg_write_p1;
  end

  // WB (p2): slot valids, write-back port and retire count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      retired <= '0;
    end else begin
      vld_p0  <= accept;
      vld_p1  <= vld_p0 & ~flush;
      vld_p2  <= vld_p1;
      wb_addr <= rd_p1;
      wb_data <= mem_sel_p1 ? mem_rd : res_p1;
      if (vld_p2)
        retired <= retired + CNT_W'(1);
    end
  end

endmodule
